// File: rtl/coffee_bus_pkg.sv
//------------------------------------------------------------------------------
// coffee_bus_pkg : shared constants and read-return tags for the memory bus
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package coffee_bus_pkg;

  localparam int unsigned c_MEM_AW_DEFAULT    = 13;
  localparam logic [15:0] c_DISP_ADDR_DEFAULT = 16'hFFFF;

  // Owner/source of the read granted in the previous cycle
  typedef enum logic [2:0] {
    SRC_NONE     = 3'd0,
    SRC_CPU_RAM  = 3'd1,
    SRC_CPU_DISP = 3'd2,
    SRC_CPU_NULL = 3'd3,
    SRC_AUX_RAM  = 3'd4,
    SRC_AUX_DISP = 3'd5,
    SRC_AUX_NULL = 3'd6
  } src_t;

  function automatic logic src_is_cpu(input src_t s);
    return (s == SRC_CPU_RAM) || (s == SRC_CPU_DISP) || (s == SRC_CPU_NULL);
  endfunction

  function automatic logic src_is_aux(input src_t s);
    return (s == SRC_AUX_RAM) || (s == SRC_AUX_DISP) || (s == SRC_AUX_NULL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addr_decode.sv
//------------------------------------------------------------------------------
// addr_decode : classifies a 16-bit word address as RAM, display or unmapped
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addr_decode
  import coffee_bus_pkg::*;
#(
  parameter int unsigned MEM_AW    = c_MEM_AW_DEFAULT,
  parameter logic [15:0] DISP_ADDR = c_DISP_ADDR_DEFAULT
) (
  input  logic [15:0] i_addr,
  output logic        o_is_ram,
  output logic        o_is_disp,
  output logic        o_is_unmapped
);

  // 17 bits so that MEM_AW = 16 still yields a valid limit
  localparam logic [16:0] c_RAM_LIMIT = 17'd1 << MEM_AW;

  logic w_is_ram;
  logic w_is_disp;

  assign w_is_ram      = ({1'b0, i_addr} < c_RAM_LIMIT);
  assign w_is_disp     = !w_is_ram && (i_addr == DISP_ADDR);
  assign o_is_ram      = w_is_ram;
  assign o_is_disp     = w_is_disp;
  assign o_is_unmapped = !w_is_ram && !w_is_disp;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter : CPU/aux arbiter for the shared 8K x 32 memory plus display reg
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import coffee_bus_pkg::*;
#(
  parameter int unsigned MEM_AW    = c_MEM_AW_DEFAULT,
  parameter logic [15:0] DISP_ADDR = c_DISP_ADDR_DEFAULT,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clock,
  input  logic              nRst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [15:0]       aux_addr,
  input  logic [31:0]       aux_wdata,
  output logic              aux_gnt,
  output logic [31:0]       aux_rdata,
  output logic              aux_rvalid,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wren,
  input  logic [31:0]       mem_q,
  output logic [15:0]       disp
);

  localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]  r_wait_cnt;
  src_t        r_src;
  logic [15:0] r_disp;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_aux_rdata;

  logic        w_cpu_is_ram, w_cpu_is_disp, w_cpu_is_null;
  logic        w_aux_is_ram, w_aux_is_disp, w_aux_is_null;
  logic        w_force;
  logic        w_cpu_gnt, w_aux_gnt, w_any_gnt;
  logic        w_sel_we, w_sel_ram, w_sel_disp, w_sel_null;
  logic [31:0] w_sel_wdata;
  src_t        w_src_nxt;
  logic [31:0] w_ret_data;
  logic        w_cpu_rvalid, w_aux_rvalid;

  addr_decode #(.MEM_AW(MEM_AW), .DISP_ADDR(DISP_ADDR)) u_cpu_dec (
    .i_addr        (cpu_addr),
    .o_is_ram      (w_cpu_is_ram),
    .o_is_disp     (w_cpu_is_disp),
    .o_is_unmapped (w_cpu_is_null)
  );

  addr_decode #(.MEM_AW(MEM_AW), .DISP_ADDR(DISP_ADDR)) u_aux_dec (
    .i_addr        (aux_addr),
    .o_is_ram      (w_aux_is_ram),
    .o_is_disp     (w_aux_is_disp),
    .o_is_unmapped (w_aux_is_null)
  );

  // Aux jumps ahead of the CPU once it has been denied MAX_WAIT times in a row
  assign w_force   = (r_wait_cnt == c_MAX_WAIT);
  assign w_aux_gnt = nRst && aux_req && (w_force || !cpu_req);
  assign w_cpu_gnt = nRst && cpu_req && !w_aux_gnt;
  assign w_any_gnt = w_cpu_gnt || w_aux_gnt;

  assign w_sel_we    = w_aux_gnt ? aux_we        : cpu_we;
  assign w_sel_ram   = w_aux_gnt ? w_aux_is_ram  : w_cpu_is_ram;
  assign w_sel_disp  = w_aux_gnt ? w_aux_is_disp : w_cpu_is_disp;
  assign w_sel_null  = w_aux_gnt ? w_aux_is_null : w_cpu_is_null;
  assign w_sel_wdata = w_aux_gnt ? aux_wdata     : cpu_wdata;

  assign cpu_gnt   = w_cpu_gnt;
  assign aux_gnt   = w_aux_gnt;
  assign mem_addr  = w_aux_gnt ? aux_addr[MEM_AW-1:0] : cpu_addr[MEM_AW-1:0];
  assign mem_wdata = w_sel_wdata;
  assign mem_wren  = w_any_gnt && w_sel_we && w_sel_ram;

  always_comb begin
    w_src_nxt = SRC_NONE;
    if (w_any_gnt && !w_sel_we) begin
      if (w_sel_ram) begin
        w_src_nxt = w_aux_gnt ? SRC_AUX_RAM : SRC_CPU_RAM;
      end else if (w_sel_disp) begin
        w_src_nxt = w_aux_gnt ? SRC_AUX_DISP : SRC_CPU_DISP;
      end else if (w_sel_null) begin
        w_src_nxt = w_aux_gnt ? SRC_AUX_NULL : SRC_CPU_NULL;
      end
    end
  end

  always_comb begin
    w_ret_data = 32'h0;
    case (r_src)
      SRC_CPU_RAM,  SRC_AUX_RAM:  w_ret_data = mem_q;
      SRC_CPU_DISP, SRC_AUX_DISP: w_ret_data = {16'h0, r_disp};
      default:                    w_ret_data = 32'h0;
    endcase
  end

  assign w_cpu_rvalid = src_is_cpu(r_src);
  assign w_aux_rvalid = src_is_aux(r_src);

  assign cpu_rvalid = w_cpu_rvalid;
  assign aux_rvalid = w_aux_rvalid;
  assign cpu_rdata  = w_cpu_rvalid ? w_ret_data : r_cpu_rdata;
  assign aux_rdata  = w_aux_rvalid ? w_ret_data : r_aux_rdata;
  assign disp       = r_disp;

  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      r_wait_cnt <= 4'd0;
    end else if (aux_req && !w_aux_gnt) begin
      if (r_wait_cnt != c_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      r_src <= SRC_NONE;
    end else begin
      r_src <= w_src_nxt;
    end
  end

  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      r_disp <= 16'h0;
    end else if (w_any_gnt && w_sel_we && w_sel_disp) begin
      r_disp <= w_sel_wdata[15:0];
    end
  end

  // Return data is captured so each port's rdata holds between its reads
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      r_cpu_rdata <= 32'h0;
      r_aux_rdata <= 32'h0;
    end else begin
      if (w_cpu_rvalid) begin
        r_cpu_rdata <= w_ret_data;
      end
      if (w_aux_rvalid) begin
        r_aux_rdata <= w_ret_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter : directed and random checks of mem_arbiter against a model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int          MEM_AW    = 13;
  localparam logic [15:0] DISP_ADDR = 16'hFFFF;
  localparam int          MAX_WAIT  = 4;
  localparam int          RAM_WORDS = 1 << MEM_AW;

  logic              clock = 1'b0;
  logic              nRst;
  logic              cpu_req, cpu_we, aux_req, aux_we;
  logic [15:0]       cpu_addr, aux_addr;
  logic [31:0]       cpu_wdata, aux_wdata;
  logic              cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid;
  logic [31:0]       cpu_rdata, aux_rdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wren;
  logic [31:0]       mem_q;
  logic [15:0]       disp;

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_AW(MEM_AW), .DISP_ADDR(DISP_ADDR), .MAX_WAIT(MAX_WAIT)) dut (
    .clock      (clock),
    .nRst       (nRst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_gnt    (aux_gnt),
    .aux_rdata  (aux_rdata),
    .aux_rvalid (aux_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .disp       (disp)
  );

  // Memory macro: registered read, old data on same-edge write
  bit [31:0] mem [RAM_WORDS];
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_q <= mem[mem_addr];
  end

  // Reference model state
  bit [31:0] ref_mem [RAM_WORDS];
  int        m_wait;
  bit [15:0] m_disp;
  bit        pend_cpu, pend_aux;
  bit [31:0] pend_data;
  bit [31:0] last_cpu, last_aux;
  bit        known_cpu, known_aux;
  bit        obs_cpu_gnt, obs_aux_gnt;
  int        aux_run, aux_max_run;
  int        n_checks, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_wait    = 0;
    m_disp    = 16'h0;
    pend_cpu  = 1'b0;
    pend_aux  = 1'b0;
    known_cpu = 1'b0;
    known_aux = 1'b0;
    aux_run   = 0;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_aux(input logic req, input logic we, input logic [15:0] a, input logic [31:0] d);
    aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 16'($urandom_range(0, 31));
      2:       return 16'h1FFF;
      3:       return 16'h2000;
      4:       return DISP_ADDR;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called at posedge+1 with inputs already driven; returns at next posedge+1
  task automatic step();
    bit          e_aux, e_cpu, e_gnt, is_ram, is_disp, we;
    logic [15:0] a;
    logic [31:0] d;
    #1;
    e_aux   = aux_req && ((m_wait >= MAX_WAIT) || !cpu_req);
    e_cpu   = cpu_req && !e_aux;
    e_gnt   = e_aux || e_cpu;
    a       = e_aux ? aux_addr  : cpu_addr;
    we      = e_aux ? aux_we    : cpu_we;
    d       = e_aux ? aux_wdata : cpu_wdata;
    is_ram  = (int'(a) < RAM_WORDS);
    is_disp = (a == DISP_ADDR);

    check("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
    check("aux_gnt", 32'(aux_gnt), 32'(e_aux));
    check("mem_addr", 32'(mem_addr), 32'(a % RAM_WORDS));
    check("mem_wren", 32'(mem_wren), 32'(e_gnt && we && is_ram));
    if (e_gnt && we && is_ram) check("mem_wdata", mem_wdata, d);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_cpu));
    check("aux_rvalid", 32'(aux_rvalid), 32'(pend_aux));
    if (pend_cpu) check("cpu_rdata", cpu_rdata, pend_data);
    else if (known_cpu) check("cpu_rdata_hold", cpu_rdata, last_cpu);
    if (pend_aux) check("aux_rdata", aux_rdata, pend_data);
    else if (known_aux) check("aux_rdata_hold", aux_rdata, last_aux);
    check("disp", 32'(disp), 32'(m_disp));

    obs_cpu_gnt = cpu_gnt;
    obs_aux_gnt = aux_gnt;
    if (aux_req && !aux_gnt) aux_run++;
    else aux_run = 0;
    if (aux_run > aux_max_run) aux_max_run = aux_run;

    if (pend_cpu) begin last_cpu = pend_data; known_cpu = 1'b1; end
    if (pend_aux) begin last_aux = pend_data; known_aux = 1'b1; end
    pend_cpu = 1'b0;
    pend_aux = 1'b0;
    if (e_gnt) begin
      if (we) begin
        if (is_ram) ref_mem[a % RAM_WORDS] = d;
        else if (is_disp) m_disp = d[15:0];
      end else begin
        pend_data = is_ram ? ref_mem[a % RAM_WORDS] : (is_disp ? {16'h0, m_disp} : 32'h0);
        pend_cpu  = e_cpu;
        pend_aux  = e_aux;
      end
    end
    if (aux_req && !e_aux) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;

    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    aux_max_run = 0;
    obs_cpu_gnt = 1'b0;
    obs_aux_gnt = 1'b0;
    reset_model();

    // Reset: requests present but nothing may be granted
    nRst = 1'b0;
    set_cpu(1'b1, 1'b1, 16'h0010, 32'h1111_1111);
    set_aux(1'b1, 1'b1, 16'h0020, 32'h2222_2222);
    repeat (2) @(posedge clock);
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_aux_gnt", 32'(aux_gnt), 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
    check("rst_disp", 32'(disp), 32'd0);
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_aux(1'b0, 1'b0, 16'h0, 32'h0);
    nRst = 1'b1;
    @(posedge clock);
    #1;

    // RAM write then read back
    set_cpu(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF); step();
    set_cpu(1'b1, 1'b0, 16'h0010, 32'h0);         step();
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    check("ram_rvalid", 32'(cpu_rvalid), 32'd1);
    check("ram_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("ram_aux_rvalid", 32'(aux_rvalid), 32'd0);
    step();

    // Display register write then read
    set_cpu(1'b1, 1'b1, DISP_ADDR, 32'h1234_5678); step();
    check("disp_value", 32'(disp), 32'h0000_5678);
    set_cpu(1'b1, 1'b0, DISP_ADDR, 32'h0);         step();
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    check("disp_rdata", cpu_rdata, 32'h0000_5678);
    step();

    // Unmapped write dropped, read returns zero
    set_cpu(1'b1, 1'b1, 16'h4000, 32'hFFFF_FFFF); step();
    set_cpu(1'b1, 1'b0, 16'h4000, 32'h0);         step();
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    check("null_rvalid", 32'(cpu_rvalid), 32'd1);
    check("null_rdata", cpu_rdata, 32'h0);
    step();

    // Aux read with CPU idle
    set_cpu(1'b1, 1'b1, 16'h0020, 32'hCAFE_F00D); step();
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_aux(1'b1, 1'b0, 16'h0020, 32'h0);         step();
    check("aux_gnt_idle", 32'(obs_aux_gnt), 32'd1);
    set_aux(1'b0, 1'b0, 16'h0, 32'h0);
    check("aux_rvalid", 32'(aux_rvalid), 32'd1);
    check("aux_rdata", aux_rdata, 32'hCAFE_F00D);
    step();

    // Contention: CPU x4 then forced aux, repeating
    set_cpu(1'b1, 1'b0, 16'h0010, 32'h0);
    set_aux(1'b1, 1'b0, 16'h0020, 32'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      check("pattern_aux", 32'(obs_aux_gnt), 32'((i % 5) == 4));
    end
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_aux(1'b0, 1'b0, 16'h0, 32'h0);
    step();

    // Reset in the cycle a read would return
    set_cpu(1'b1, 1'b0, 16'h0010, 32'h0); step();
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    nRst = 1'b0;
    #1;
    check("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("midrst_disp", 32'(disp), 32'd0);
    reset_model();
    @(posedge clock);
    #1;
    nRst = 1'b1;
    repeat (3) step();

    // Random traffic honouring the hold-until-grant contract
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || obs_cpu_gnt)
        set_cpu(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!aux_req || obs_aux_gnt)
        set_aux(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      step();
    end
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_aux(1'b0, 1'b0, 16'h0, 32'h0);
    step();

    check("aux_max_wait", 32'(aux_max_run <= MAX_WAIT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
